// File: rtl/ghost_pkg.sv
// Shared bullet-overlay types: per-slot projectile state and screen coordinate width.
// No logic; imported by the fire controller and the overlay core.
package ghost_pkg;

  localparam int COORD_W = 11;

  typedef struct packed {
    logic               active;
    logic               dir;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } bullet_t;

endpackage

// File: rtl/bullet_fire_ctrl.sv
// Fire button front end: 2-FF synchronizer, rising-edge detect, one-per-frame pending request
// and post-spawn cooldown in frames. pending is registered; consumed on frame_start.
module bullet_fire_ctrl
  import ghost_pkg::*;
#(
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset_sys,
  input  logic fire,
  input  logic frame_start,
  input  logic slot_free,
  output logic pending
);

  localparam int CW = $clog2(COOLDOWN + 1);

  logic [2:0]    fire_sync_q, fire_sync_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          fire_pulse;

  always_comb begin
    fire_sync_d = {fire_sync_q[1:0], fire};
    fire_pulse  = fire_sync_q[1] & ~fire_sync_q[2];
    pending_d   = pending_q;
    cool_d      = cool_q;
    if (frame_start) begin
      // A pulse landing on the tick is kept for the next frame unless one is already queued.
      pending_d = fire_pulse && (cool_q == '0) && !pending_q;
      if (pending_q) begin
        if (slot_free) cool_d = CW'(COOLDOWN);
      end else if (cool_q != '0) begin
        cool_d = cool_q - 1'b1;
      end
    end else if (fire_pulse && (cool_q == '0)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_sys) begin
    if (!reset_sys) begin
      fire_sync_q <= '0;
      pending_q   <= 1'b0;
      cool_q      <= '0;
    end else begin
      fire_sync_q <= fire_sync_d;
      pending_q   <= pending_d;
      cool_q      <= cool_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/vga_bullet_core.sv
// Pixel-stream bullet overlay: slot array moved once per frame, spawn from fire controller,
// and a registered colour mux (1 clk latency, no backpressure on the pixel stream).
module vga_bullet_core
  import ghost_pkg::*;
#(
  parameter int CD          = 12,
  parameter int MAX_BULLETS = 4,
  parameter int BULLET_W    = 8,
  parameter int BULLET_H    = 2,
  parameter int SPEED       = 6,
  parameter int COOLDOWN    = 8,
  parameter int HMAX        = 640
) (
  input  logic                   clk,
  input  logic                   reset_sys,
  input  logic [COORD_W-1:0]     x,
  input  logic [COORD_W-1:0]     y,
  input  logic                   frame_start,
  input  logic [CD-1:0]          si_rgb,
  output logic [CD-1:0]          so_rgb,
  input  logic                   fire,
  input  logic                   dir,
  input  logic [COORD_W-1:0]     origin_x,
  input  logic [COORD_W-1:0]     origin_y,
  input  logic [CD-1:0]          bullet_rgb,
  output logic [MAX_BULLETS-1:0] active_mask
);

  localparam int IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
  localparam logic signed [COORD_W:0] X_MAX = (COORD_W + 1)'(HMAX - BULLET_W);
  localparam logic signed [COORD_W:0] SPD   = (COORD_W + 1)'(SPEED);

  bullet_t                slot_q [MAX_BULLETS];
  bullet_t                slot_d [MAX_BULLETS];
  logic [MAX_BULLETS-1:0] active_mask_q, active_mask_d;
  logic [CD-1:0]          so_rgb_q, so_rgb_d;
  logic                   pending, slot_free, hit;
  logic [IDX_W-1:0]       free_idx;
  logic signed [COORD_W:0] nx;

  bullet_fire_ctrl #(.COOLDOWN(COOLDOWN)) u_fire_ctrl (
    .clk        (clk),
    .reset_sys  (reset_sys),
    .fire       (fire),
    .frame_start(frame_start),
    .slot_free  (slot_free),
    .pending    (pending)
  );

  always_comb begin
    slot_free = 1'b0;
    free_idx  = '0;
    nx        = '0;
    hit       = 1'b0;
    // Descending scan so the lowest free index wins; uses pre-tick occupancy only.
    for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
      if (!slot_q[i].active) begin
        slot_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
    for (int i = 0; i < MAX_BULLETS; i++) begin
      slot_d[i] = slot_q[i];
      nx = slot_q[i].dir ? $signed({1'b0, slot_q[i].x}) - SPD
                         : $signed({1'b0, slot_q[i].x}) + SPD;
      if (frame_start && slot_q[i].active) begin
        if (nx < 0 || nx > X_MAX) slot_d[i].active = 1'b0;
        else                      slot_d[i].x      = nx[COORD_W-1:0];
      end
      if (slot_q[i].active
          && {1'b0, x} >= {1'b0, slot_q[i].x}
          && {1'b0, x} <  {1'b0, slot_q[i].x} + (COORD_W + 1)'(BULLET_W)
          && {1'b0, y} >= {1'b0, slot_q[i].y}
          && {1'b0, y} <  {1'b0, slot_q[i].y} + (COORD_W + 1)'(BULLET_H)) begin
        hit = 1'b1;
      end
    end
    if (frame_start && pending && slot_free) begin
      slot_d[free_idx] = '{active: 1'b1, dir: dir, x: origin_x, y: origin_y};
    end
    for (int i = 0; i < MAX_BULLETS; i++) active_mask_d[i] = slot_d[i].active;
    so_rgb_d = hit ? bullet_rgb : si_rgb;
  end

  always_ff @(posedge clk or negedge reset_sys) begin
    if (!reset_sys) begin
      for (int i = 0; i < MAX_BULLETS; i++) slot_q[i] <= '0;
      active_mask_q <= '0;
      so_rgb_q      <= '0;
    end else begin
      for (int i = 0; i < MAX_BULLETS; i++) slot_q[i] <= slot_d[i];
      active_mask_q <= active_mask_d;
      so_rgb_q      <= so_rgb_d;
    end
  end

  assign so_rgb      = so_rgb_q;
  assign active_mask = active_mask_q;

endmodule

// File: tb/tb_vga_bullet_core.sv
// Bench for vga_bullet_core: behavioural bullet/fire model, pixel scoreboard, frame-mask checks.
module tb_vga_bullet_core;

  logic        clk = 1'b0;
  logic        reset_sys = 1'b0;
  logic        frame_start = 1'b0;
  logic        fire = 1'b0;
  logic        dir = 1'b0;
  logic [10:0] x = '0, y = '0, origin_x = '0, origin_y = '0;
  logic [11:0] si_rgb = '0;
  logic [11:0] bullet_rgb = 12'hF0F;
  logic [11:0] so_rgb;
  logic [3:0]  active_mask;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  bit m_act[4];
  bit m_dir[4];
  int m_x[4];
  int m_y[4];
  bit m_pend;
  int m_cool;
  bit f1, f2, f3;

  vga_bullet_core dut (
    .clk        (clk),
    .reset_sys  (reset_sys),
    .x          (x),
    .y          (y),
    .frame_start(frame_start),
    .si_rgb     (si_rgb),
    .so_rgb     (so_rgb),
    .fire       (fire),
    .dir        (dir),
    .origin_x   (origin_x),
    .origin_y   (origin_y),
    .bullet_rgb (bullet_rgb),
    .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hit(input int px, input int py);
    bit h = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + 8 && py >= m_y[i] && py < m_y[i] + 2) h = 1'b1;
    return h;
  endfunction

  function automatic logic [3:0] m_mask();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = m_act[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_pend = 0; m_cool = 0; f1 = 0; f2 = 0; f3 = 0;
  endtask

  // One pixel clock: drive, predict, advance model, then check after the edge.
  task automatic step(input bit fs, input int px, input int py);
    logic [11:0] si;
    bit pulse, new_pend;
    int free, nx;
    si = 12'($urandom);
    frame_start = fs; x = 11'(px); y = 11'(py); si_rgb = si;
    exp_q.push_back(m_hit(px, py) ? bullet_rgb : si);
    pulse = f2 && !f3;
    if (fs) begin
      free = -1;
      for (int i = 0; i < 4; i++) if (!m_act[i] && free < 0) free = i;
      for (int i = 0; i < 4; i++) begin
        if (m_act[i]) begin
          nx = m_dir[i] ? m_x[i] - 6 : m_x[i] + 6;
          if (nx < 0 || nx > 632) m_act[i] = 0;
          else m_x[i] = nx;
        end
      end
      new_pend = pulse && m_cool == 0 && !m_pend;
      if (m_pend) begin
        if (free >= 0) begin
          m_act[free] = 1; m_dir[free] = dir; m_x[free] = int'(origin_x); m_y[free] = int'(origin_y);
          m_cool = 8;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end
      m_pend = new_pend;
    end else if (pulse && m_cool == 0) begin
      m_pend = 1;
    end
    f3 = f2; f2 = f1; f1 = fire;
    @(posedge clk); #1;
    chk_eq(fs ? "so_rgb_tick" : "so_rgb", so_rgb, exp_q.pop_front());
    if (fs) chk_eq("active_mask", active_mask, m_mask());
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 2000, 2000);
  endtask

  task automatic frame();
    step(1, 0, 0);
    idle(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press();
    fire = 1'b1; idle(4);
    fire = 1'b0; idle(4);
  endtask

  task automatic spawn_at(input int ox, input int oy, input bit d);
    origin_x = 11'(ox); origin_y = 11'(oy); dir = d;
    press();
    frame();
  endtask

  task automatic scan(input int x0, input int y0, input int w, input int h);
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) step(0, x0 + i, y0 + j);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_so_rgb", so_rgb, 12'h000);
    chk_eq("reset_mask", active_mask, 4'h0);
    reset_sys = 1'b1;
    idle(4);

    // Spawn at (100,200) moving +x, then one move.
    spawn_at(100, 200, 0);
    chk_eq("spawn_slot0", active_mask, 4'h1);
    scan(96, 199, 14, 4);
    frame();
    scan(102, 199, 14, 4);

    // Held button fires once; a second press inside cooldown is ignored.
    frames(8);
    fire = 1'b1; idle(4);
    frames(10);
    fire = 1'b0; idle(2);
    chk_eq("held_one_shot", active_mask, 4'h3);
    press(); frame();
    frames(2);
    press(); frame();
    frames(2);
    chk_eq("cooldown_ignore", active_mask, 4'h7);

    // Asynchronous reset mid-frame with three live bullets.
    step(0, m_x[0], m_y[0]);
    #3 reset_sys = 1'b0;
    #1;
    chk_eq("midframe_rst_so_rgb", so_rgb, 12'h000);
    chk_eq("midframe_rst_mask", active_mask, 4'h0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1;
    reset_sys = 1'b1;
    idle(3);

    // -x bullet near the left edge retires without wrapping.
    spawn_at(10, 50, 1);
    frame();
    scan(0, 49, 14, 3);
    frame();
    chk_eq("left_retire", active_mask, 4'h0);
    scan(626, 50, 14, 1);

    // Pulse coinciding with frame_start spawns on the following tick.
    frames(6);
    origin_x = 11'd600; origin_y = 11'd400; dir = 1'b0;
    fire = 1'b1; idle(2);
    frame();
    chk_eq("tick_pulse_no_spawn", active_mask, 4'h0);
    fire = 1'b0; idle(2);
    frame();
    chk_eq("tick_pulse_spawn", active_mask, 4'h1);
    frames(8);

    // Full array: drop while full, no reuse of a slot retiring on the same tick.
    spawn_at(0, 300, 0);   frames(8);
    spawn_at(0, 320, 0);   frames(8);
    spawn_at(150, 340, 1); frames(8);
    spawn_at(0, 360, 0);
    chk_eq("all_full", active_mask, 4'hF);
    frames(8);
    press(); frame();
    chk_eq("drop_full", active_mask, 4'hF);
    frames(7);
    press(); frame();
    chk_eq("retire_no_reuse", active_mask, 4'hB);
    press(); frame();
    chk_eq("reuse_next_tick", active_mask, 4'hF);
    scan(146, 339, 12, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
